// File: rtl/sequence_generator.sv
// Serial pattern transmitter: emits PATTERN MSB-first, count times, with gap idle cycles between repetitions.
// All outputs registered; first bit appears one cycle after an accepted start.
module sequence_generator #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1011,
  parameter logic             IDLE_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] count,
  input  logic [3:0] gap,
  input  logic       abort,
  output logic       data,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int               IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_bit_idx;
  logic [7:0]       r_reps;
  logic [3:0]       r_gap_len;
  logic [3:0]       r_gap_cnt;
  logic             r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_idx_dec;
  logic [7:0]       w_reps_dec;

  assign w_idx_dec  = r_bit_idx - 1'b1;
  // Repetition counter saturates at zero rather than wrapping.
  assign w_reps_dec = (r_reps == 8'd0) ? 8'd0 : r_reps - 8'd1;

  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_reps    <= '0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
      r_data    <= IDLE_BIT;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_data  <= IDLE_BIT;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          // abort beats a simultaneous start
          if (start && !abort && count != 8'd0) begin
            r_state   <= S_SEND;
            r_reps    <= count;
            r_gap_len <= gap;
            r_bit_idx <= LAST_IDX;
            r_data    <= PATTERN[PAT_W-1];
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_reps    <= '0;
            r_gap_cnt <= '0;
            r_data    <= IDLE_BIT;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_bit_idx != '0) begin
            r_bit_idx <= w_idx_dec;
            r_data    <= PATTERN[w_idx_dec];
          end else begin
            r_reps <= w_reps_dec;
            if (w_reps_dec == 8'd0) begin
              r_state <= S_DONE;
              r_data  <= IDLE_BIT;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap_len == 4'd0) begin
              r_bit_idx <= LAST_IDX;
              r_data    <= PATTERN[PAT_W-1];
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= r_gap_len;
              r_data    <= IDLE_BIT;
              r_valid   <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_reps    <= '0;
            r_gap_cnt <= '0;
            r_data    <= IDLE_BIT;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_gap_cnt == 4'd1) begin
            r_state   <= S_SEND;
            r_gap_cnt <= '0;
            r_bit_idx <= LAST_IDX;
            r_data    <= PATTERN[PAT_W-1];
            r_valid   <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: expected {data,valid,busy,done} frames are queued per run
// and compared one per cycle on the falling edge.
module tb_sequence_generator;

  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] count = 8'd0;
  logic [3:0] gap = 4'd0;
  logic       abort = 1'b0;
  logic       data, valid, busy, done;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [3:0] sb[$];
  logic [3:0] exp_f;
  logic [3:0] obs;
  logic [3:0] det_sh;
  int         det_hits;

  sequence_generator #(.PAT_W(4), .PATTERN(4'b1011), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .gap(gap), .abort(abort),
    .data(data), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected frames for one run, from first bit through the done pulse.
  task automatic push_run(input int n, input int g);
    for (int r = 0; r < n; r++) begin
      for (int b = 3; b >= 0; b--) sb.push_back({PAT[b], 1'b1, 1'b1, 1'b0});
      if (r < n - 1) for (int k = 0; k < g; k++) sb.push_back(4'b0010);
    end
    sb.push_back(4'b0001);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b1; count = 8'd1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    obs = {data, valid, busy, done};
    if (obs !== 4'b0000) $display("FAIL reset_state: got %b want 0000", obs);
    else pass_cnt++;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    obs = {data, valid, busy, done};
    if (obs !== 4'b0000) $display("FAIL reset_release_idle: got %b want 0000", obs);
    else pass_cnt++;
  endtask

  task automatic test_single;
    start = 1'b1; count = 8'd1; gap = 4'd0;
    push_run(1, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL single: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    det_sh = '0; det_hits = 0;
    start = 1'b1; count = 8'd2; gap = 4'd0;
    push_run(2, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      if (valid) begin
        det_sh = {det_sh[2:0], data};
        if (det_sh == PAT) det_hits++;
      end
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL back_to_back: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
    chk_cnt++;
    if (det_hits !== 2) $display("FAIL b2b_pattern_hits: got %0d want 2", det_hits);
    else pass_cnt++;
  endtask

  task automatic test_gap;
    int busy_cycles;
    busy_cycles = 0;
    start = 1'b1; count = 8'd2; gap = 4'd3;
    push_run(2, 3);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      if (busy) busy_cycles++;
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL gap_run: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy_cycles !== 11) $display("FAIL gap_busy_cycles: got %0d want 11", busy_cycles);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start;
    int bits, dones, cyc;
    bits = 0; dones = 0; cyc = 0;
    start = 1'b1; count = 8'd0; gap = 4'd2;
    repeat (3) sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL count_zero_ignored: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
    start = 1'b1; count = 8'd3; gap = 4'd1;
    push_run(3, 1);
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      // re-start and change count/gap while the run is active
      start = (cyc % 3 == 0);
      count = 8'd7; gap = 4'd5;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      if (valid) bits++;
      if (done) dones++;
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL start_while_busy: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
    start = 1'b0;
    chk_cnt++;
    if (bits !== 12 || dones !== 1) $display("FAIL busy_run_totals: got bits=%0d done=%0d want 12/1", bits, dones);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_done_restart;
    int i;
    i = 0;
    start = 1'b1; count = 8'd1; gap = 4'd0;
    push_run(1, 0);
    push_run(1, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL done_restart: got %b want %b", obs, exp_f);
      else pass_cnt++;
      if (i == 4) start = 1'b1;
      i++;
    end
    start = 1'b0;
  endtask

  task automatic test_abort;
    start = 1'b1; abort = 1'b1; count = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_cnt++;
    obs = {data, valid, busy, done};
    if (obs !== 4'b0000) $display("FAIL abort_beats_start: got %b want 0000", obs);
    else pass_cnt++;
    start = 1'b1; count = 8'd2; gap = 4'd0;
    sb.push_back(4'b1110);
    sb.push_back(4'b0110);
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL abort_run: got %b want %b", obs, exp_f);
      else pass_cnt++;
      if (i == 1) abort = 1'b1;
    end
    start = 1'b1; count = 8'd1;
    push_run(1, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL after_abort: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    start = 1'b1; count = 8'd2; gap = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    obs = {data, valid, busy, done};
    if (obs !== 4'b1110) $display("FAIL mid_first_bit: got %b want 1110", obs);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++;
    obs = {data, valid, busy, done};
    if (obs !== 4'b0000) $display("FAIL async_reset: got %b want 0000", obs);
    else pass_cnt++;
    #3 reset = 1'b1;
    repeat (4) sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_f = sb.pop_front();
      obs = {data, valid, busy, done};
      chk_cnt++;
      if (obs !== exp_f) $display("FAIL post_reset_idle: got %b want %b", obs, exp_f);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_ignore_start();
    test_done_restart();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
